// File: rtl/axi_mst_read_mb_if.sv
// AXI4 read-address/read-data channels plus the AXI-Stream output of the multi-burst read master.
// master modport is the read engine's view; slave is the memory/sink side.
interface axi_mst_read_mb_if #(
   parameter int ID_WIDTH   = 1,
   parameter int DATA_WIDTH = 64
);
   logic [ID_WIDTH-1:0]     m_axi_arid;
   logic [31:0]             m_axi_araddr;
   logic [7:0]              m_axi_arlen;
   logic [2:0]              m_axi_arsize;
   logic [1:0]              m_axi_arburst;
   logic                    m_axi_arlock;
   logic [3:0]              m_axi_arcache;
   logic [2:0]              m_axi_arprot;
   logic [3:0]              m_axi_arregion;
   logic [3:0]              m_axi_arqos;
   logic                    m_axi_arvalid;
   logic                    m_axi_arready;
   logic [ID_WIDTH-1:0]     m_axi_rid;
   logic [DATA_WIDTH-1:0]   m_axi_rdata;
   logic [1:0]              m_axi_rresp;
   logic                    m_axi_rlast;
   logic                    m_axi_rvalid;
   logic                    m_axi_rready;
   logic                    m_axis_tvalid;
   logic [DATA_WIDTH-1:0]   m_axis_tdata;
   logic [DATA_WIDTH/8-1:0] m_axis_tstrb;
   logic                    m_axis_tlast;
   logic                    m_axis_tready;

   modport master (
      output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
             m_axi_arcache, m_axi_arprot, m_axi_arregion, m_axi_arqos, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      output m_axi_rready,
      output m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast,
      input  m_axis_tready
   );

   modport slave (
      input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
             m_axi_arcache, m_axi_arprot, m_axi_arregion, m_axi_arqos, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      input  m_axi_rready,
      input  m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast,
      output m_axis_tready
   );
endinterface

// File: rtl/axi_mst_read_mb.sv
// Multi-burst AXI4 read master streaming a contiguous region to AXI-Stream; R beat to tvalid in 1 cycle.
// Bursts (<= MAX_BURST, never crossing 4 kB) issue only when FIFO credits cover them; rready = FIFO not full.
module axi_mst_read_mb #(
   parameter int ID_WIDTH   = 1,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 32
) (
   input  logic               clk,
   input  logic               rstn,
   axi_mst_read_mb_if.master  bus,
   input  logic               START_REG,
   input  logic [31:0]        ADDR_REG,
   input  logic [31:0]        LENGTH_REG,
   output logic               RIDLE_REG,
   output logic               RDONE_REG,
   output logic               RERR_REG
);
   localparam int BPB = DATA_WIDTH / 8;
   localparam int BSH = $clog2(BPB);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_END} state_t;
   state_t state_q, state_d;

   logic [31:0]     addr_q, rem_q, length_q, rx_cnt_q;
   logic [31:0]     addr_d, rem_d;
   logic [8:0]      len_q, len_d;
   logic [CW-1:0]   credits_q;
   logic            rerr_q;
   logic            ar_hs, r_hs, pop, last_flag;

   logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
   logic [DATA_WIDTH:0] head;
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       cnt_q;
   logic                fifo_full, fifo_empty;
   logic                unused_r;

   // min(remaining, MAX_BURST, beats left before the next 4 kB boundary)
   function automatic logic [8:0] burst_len(input logic [11:0] off, input logic [31:0] rem);
      logic [12:0] room;
      room = 13'((14'd4096 - {2'b00, off}) >> BSH);
      if (rem <= 32'(MAX_BURST) && rem <= {19'd0, room}) return rem[8:0];
      else if (13'(MAX_BURST) <= room)                    return 9'(MAX_BURST);
      else                                                 return room[8:0];
   endfunction

   assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (cnt_q == '0);
   assign ar_hs      = bus.m_axi_arvalid & bus.m_axi_arready;
   assign r_hs       = bus.m_axi_rvalid & bus.m_axi_rready;
   assign pop        = bus.m_axis_tvalid & bus.m_axis_tready;
   assign last_flag  = (rx_cnt_q == length_q - 32'd1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:  state_d = S_IDLE;
         S_IDLE:  if (START_REG) state_d = S_LOAD;
         S_LOAD:  state_d = (LENGTH_REG == 32'd0) ? S_DRAIN : S_ISSUE;
         S_ISSUE: if (ar_hs && rem_q == {23'd0, len_q}) state_d = S_DRAIN;
         S_DRAIN: if (rx_cnt_q == length_q && fifo_empty) state_d = S_END;
         S_END:   if (!START_REG) state_d = S_IDLE;
         default: state_d = S_INIT;
      endcase
   end

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (state_q == S_LOAD) begin
         addr_d = ADDR_REG & ~32'(BPB - 1);
         rem_d  = LENGTH_REG;
      end else if (ar_hs) begin
         addr_d = addr_q + ({23'd0, len_q} << BSH);
         rem_d  = rem_q - {23'd0, len_q};
      end
   end

   // the next burst length is precomputed so it is a register while arvalid is up
   assign len_d = burst_len(addr_d[11:0], rem_d);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= S_INIT;
         addr_q    <= '0;
         rem_q     <= '0;
         len_q     <= 9'd1;
         length_q  <= '0;
         rx_cnt_q  <= '0;
         credits_q <= CW'(FIFO_DEPTH);
         rerr_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         if (state_q == S_LOAD || ar_hs) len_q <= len_d;
         if (state_q == S_LOAD) begin
            length_q  <= LENGTH_REG;
            rx_cnt_q  <= '0;
            rerr_q    <= 1'b0;
            credits_q <= CW'(FIFO_DEPTH);
         end else begin
            if (r_hs) begin
               rx_cnt_q <= rx_cnt_q + 32'd1;
               if (bus.m_axi_rresp != 2'b00) rerr_q <= 1'b1;
            end
            credits_q <= credits_q - (ar_hs ? CW'(len_q) : CW'(0)) + CW'(pop);
         end
         if (r_hs) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_q + CW'(r_hs) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (r_hs) mem[wr_ptr_q] <= {last_flag, bus.m_axi_rdata};
   end

   assign head = mem[rd_ptr_q];

   assign bus.m_axi_arid     = '0;
   assign bus.m_axi_araddr   = addr_q;
   assign bus.m_axi_arlen    = 8'(len_q - 9'd1);
   assign bus.m_axi_arsize   = 3'(BSH);
   assign bus.m_axi_arburst  = 2'b01;
   assign bus.m_axi_arlock   = 1'b0;
   assign bus.m_axi_arcache  = 4'b0000;
   assign bus.m_axi_arprot   = 3'b010;
   assign bus.m_axi_arregion = 4'd0;
   assign bus.m_axi_arqos    = 4'd0;
   // credits only grow while a burst waits, so arvalid cannot drop before arready
   assign bus.m_axi_arvalid  = (state_q == S_ISSUE) && (credits_q >= CW'(len_q));
   assign bus.m_axi_rready   = ~fifo_full;

   assign bus.m_axis_tvalid  = ~fifo_empty;
   assign bus.m_axis_tdata   = head[DATA_WIDTH-1:0];
   assign bus.m_axis_tlast   = head[DATA_WIDTH] & ~fifo_empty;
   assign bus.m_axis_tstrb   = '1;

   // beat sequencing relies on the local count, not on rid/rlast
   assign unused_r = ^{bus.m_axi_rid, bus.m_axi_rlast};

   assign RIDLE_REG = (state_q == S_IDLE);
   assign RDONE_REG = (state_q == S_END);
   assign RERR_REG  = rerr_q;
endmodule

// File: tb/tb_axi_mst_read_mb.sv
// Bench for axi_mst_read_mb: randomized AXI memory model (rdata = address) and stalling AXIS sink,
// checked against a burst-split/data reference computed from the transfer rules.
module tb_axi_mst_read_mb;
   localparam int DW = 64;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        START_REG = 1'b0;
   logic [31:0] ADDR_REG = '0;
   logic [31:0] LENGTH_REG = '0;
   logic        RIDLE_REG, RDONE_REG, RERR_REG;

   axi_mst_read_mb_if #(.ID_WIDTH(1), .DATA_WIDTH(DW)) bus ();

   axi_mst_read_mb #(.ID_WIDTH(1), .DATA_WIDTH(DW), .MAX_BURST(16), .FIFO_DEPTH(32)) dut (
      .clk(clk), .rstn(rstn), .bus(bus),
      .START_REG(START_REG), .ADDR_REG(ADDR_REG), .LENGTH_REG(LENGTH_REG),
      .RIDLE_REG(RIDLE_REG), .RDONE_REG(RDONE_REG), .RERR_REG(RERR_REG)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;
   int p_arrdy = 100, p_rvld = 100, p_trdy = 100;
   int err_beat = -1, r_total = 0, beat_idx = 0, ar_unstable = 0;
   int first_arv = -1, first_r = -1, first_tv = -1, start_cyc = 0, done_cyc = 0;
   bit ar_wait = 0, r_hold = 0;
   logic [31:0] w_addr;
   logic [7:0]  w_len;
   logic [31:0] obs_addr[$], pend_addr[$], exp_ar_addr[$];
   logic [7:0]  obs_len[$];
   int          pend_len[$], exp_ar_len[$];
   logic [63:0] out_dat[$], exp_dat[$];
   bit          out_last[$];

   // memory slave + stream sink; inputs change and handshakes are decided at negedge
   initial begin
      bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rid = '0; bus.m_axi_rdata = '0;
      bus.m_axi_rresp = 0; bus.m_axi_rlast = 0; bus.m_axis_tready = 0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axis_tready = 0;
            pend_addr.delete(); pend_len.delete(); beat_idx = 0; ar_wait = 0; r_hold = 0;
         end else begin
            if (ar_wait && (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_araddr !== w_addr ||
                            bus.m_axi_arlen !== w_len)) ar_unstable++;
            if (bus.m_axi_arvalid === 1'b1 && first_arv < 0) first_arv = cyc;
            if (bus.m_axis_tvalid === 1'b1 && first_tv < 0) first_tv = cyc;
            if (pend_len.size() > 0 && (r_hold || $urandom_range(99) < p_rvld)) begin
               bus.m_axi_rvalid = 1;
               bus.m_axi_rdata  = {32'd0, pend_addr[0] + 32'(beat_idx * 8)};
               bus.m_axi_rresp  = (r_total == err_beat) ? 2'b10 : 2'b00;
               bus.m_axi_rlast  = (beat_idx == pend_len[0] - 1);
            end else bus.m_axi_rvalid = 0;
            r_hold = bus.m_axi_rvalid && !bus.m_axi_rready;
            if (bus.m_axi_rvalid && bus.m_axi_rready) begin
               if (first_r < 0) first_r = cyc;
               r_total++; beat_idx++;
               if (beat_idx == pend_len[0]) begin
                  void'(pend_addr.pop_front()); void'(pend_len.pop_front()); beat_idx = 0;
               end
            end
            bus.m_axi_arready = ($urandom_range(99) < p_arrdy);
            if (bus.m_axi_arvalid === 1'b1 && bus.m_axi_arready) begin
               obs_addr.push_back(bus.m_axi_araddr); obs_len.push_back(bus.m_axi_arlen);
               pend_addr.push_back(bus.m_axi_araddr); pend_len.push_back(int'(bus.m_axi_arlen) + 1);
               ar_wait = 0;
            end else begin
               ar_wait = (bus.m_axi_arvalid === 1'b1);
               w_addr = bus.m_axi_araddr; w_len = bus.m_axi_arlen;
            end
            bus.m_axis_tready = ($urandom_range(99) < p_trdy);
            if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready) begin
               out_dat.push_back(bus.m_axis_tdata); out_last.push_back(bus.m_axis_tlast);
            end
         end
      end
   end

   // reference: aligned start, bursts of min(rem, 16, beats to 4 kB), data = beat address
   function automatic void model(input logic [31:0] a, input int unsigned n);
      logic [31:0] p;
      int unsigned rem, room, l;
      exp_dat.delete(); exp_ar_addr.delete(); exp_ar_len.delete();
      p = a & ~32'h7;
      for (int unsigned i = 0; i < n; i++) exp_dat.push_back({32'd0, p + 8 * i});
      rem = n;
      while (rem > 0) begin
         room = (4096 - p % 4096) / 8;
         l = (rem < 16) ? rem : 16;
         if (room < l) l = room;
         exp_ar_addr.push_back(p); exp_ar_len.push_back(int'(l));
         p += l * 8; rem -= l;
      end
   endfunction

   function automatic int data_errs();
      int e = 0;
      if (out_dat.size() != exp_dat.size()) return 100000;
      foreach (exp_dat[i])
         if (out_dat[i] !== exp_dat[i] || out_last[i] != (i == exp_dat.size() - 1)) e++;
      return e;
   endfunction

   function automatic int ar_errs();
      int e = 0;
      if (obs_addr.size() != exp_ar_addr.size()) return 100000;
      foreach (exp_ar_addr[i])
         if (obs_addr[i] !== exp_ar_addr[i] || int'(obs_len[i]) + 1 != exp_ar_len[i]) e++;
      return e;
   endfunction

   task automatic start_xfer(input logic [31:0] a, input int unsigned n);
      @(negedge clk);
      obs_addr.delete(); obs_len.delete(); out_dat.delete(); out_last.delete();
      first_arv = -1; first_r = -1; first_tv = -1; r_total = 0; ar_unstable = 0;
      model(a, n);
      ADDR_REG = a; LENGTH_REG = n; START_REG = 1; start_cyc = cyc;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int t = 0;
      while (RDONE_REG !== 1'b1 && t < budget) begin @(negedge clk); t++; end
      ok = (RDONE_REG === 1'b1);
      done_cyc = cyc;
   endtask

   task automatic finish_xfer();
      START_REG = 0;
      for (int t = 0; t < 5 && RIDLE_REG !== 1'b1; t++) @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axis_tvalid, bus.m_axis_tlast,
           RIDLE_REG, RDONE_REG, RERR_REG, bus.m_axi_rready} !== {1'b0, 32'd0, 8'd0, 6'b000001}) begin
         n_bad++;
         $display("FAIL reset_values: arv=%b araddr=%h arlen=%0d tv=%b tl=%b idle=%b done=%b err=%b rrdy=%b, want 0 0 0 0 0 0 0 0 1",
                  bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axis_tvalid, bus.m_axis_tlast,
                  RIDLE_REG, RDONE_REG, RERR_REG, bus.m_axi_rready);
      end
      n_cmp++;
      if ({bus.m_axi_arid, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arlock, bus.m_axi_arcache,
           bus.m_axi_arprot, bus.m_axi_arregion, bus.m_axi_arqos, bus.m_axis_tstrb} !==
          {1'b0, 3'd3, 2'b01, 1'b0, 4'd0, 3'b010, 4'd0, 4'd0, 8'hFF}) begin
         n_bad++;
         $display("FAIL fixed_ar_fields: size=%0d burst=%b prot=%b cache=%h strb=%h, want 3 01 010 0 ff",
                  bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arprot, bus.m_axi_arcache, bus.m_axis_tstrb);
      end
      rstn = 1;
      n_cmp++;
      if (RIDLE_REG !== 1'b0) begin n_bad++; $display("FAIL ridle_init: got %b want 0", RIDLE_REG); end
      @(negedge clk);
      n_cmp++;
      if (RIDLE_REG !== 1'b1) begin n_bad++; $display("FAIL ridle_after_reset: got %b want 1", RIDLE_REG); end
   endtask

   task automatic test_single();
      bit ok;
      p_arrdy = 100; p_rvld = 100; p_trdy = 100;
      start_xfer(32'h1000, 8);
      wait_done(300, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL single_done: RDONE=%b want 1", RDONE_REG); end
      n_cmp++;
      if (obs_addr.size() != 1 || obs_addr[0] !== 32'h1000 || obs_len[0] !== 8'd7) begin
         n_bad++; $display("FAIL single_ar: got %0d ARs, want 1 at 1000 arlen 7", obs_addr.size());
      end
      n_cmp++;
      if (first_arv - start_cyc != 2) begin
         n_bad++; $display("FAIL start_to_arvalid: got %0d cycles want 2", first_arv - start_cyc);
      end
      n_cmp++;
      if (first_tv - first_r != 1) begin
         n_bad++; $display("FAIL r_to_tvalid: got %0d cycles want 1", first_tv - first_r);
      end
      n_cmp++;
      if (data_errs() != 0) begin
         n_bad++; $display("FAIL single_data: %0d bad beats of %0d, want 0 of 8", data_errs(), out_dat.size());
      end
      finish_xfer();
   endtask

   task automatic test_split();
      bit ok;
      start_xfer(32'h0FC0, 64);
      wait_done(1000, ok);
      n_cmp++;
      if (!ok || obs_addr.size() != 5) begin
         n_bad++; $display("FAIL split_count: done=%b ARs=%0d, want 1 5", ok, obs_addr.size());
      end
      n_cmp++;
      if (ar_errs() != 0) begin n_bad++; $display("FAIL split_ar: %0d bad ARs, want 0", ar_errs()); end
      n_cmp++;
      if (data_errs() != 0) begin
         n_bad++; $display("FAIL split_data: %0d bad beats (got %0d beats), want 0 (64)", data_errs(), out_dat.size());
      end
      finish_xfer();
   endtask

   task automatic test_backpressure();
      bit ok;
      int sum = 0;
      p_trdy = 0;
      start_xfer(32'h4000, 128);
      repeat (150) @(negedge clk);
      foreach (obs_len[i]) sum += int'(obs_len[i]) + 1;
      n_cmp++;
      if (obs_addr.size() != 2 || sum != 32 || bus.m_axi_arvalid !== 1'b0) begin
         n_bad++; $display("FAIL bp_throttle: ARs=%0d beats=%0d arvalid=%b, want 2 32 0",
                           obs_addr.size(), sum, bus.m_axi_arvalid);
      end
      p_trdy = 100;
      wait_done(2000, ok);
      n_cmp++;
      if (!ok || ar_errs() != 0) begin n_bad++; $display("FAIL bp_ar: done=%b bad ARs=%0d, want 1 0", ok, ar_errs()); end
      n_cmp++;
      if (data_errs() != 0) begin n_bad++; $display("FAIL bp_data: %0d bad beats, want 0", data_errs()); end
      finish_xfer();
   endtask

   task automatic test_random();
      bit ok;
      p_arrdy = $urandom_range(30, 90); p_rvld = $urandom_range(30, 90); p_trdy = $urandom_range(30, 90);
      start_xfer($urandom & 32'h0FFF_FFFF, 1000);
      wait_done(30000, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL rand_done: timed out, RDONE=%b want 1", RDONE_REG); end
      n_cmp++;
      if (ar_errs() != 0) begin n_bad++; $display("FAIL rand_ar: %0d bad ARs, want 0", ar_errs()); end
      n_cmp++;
      if (data_errs() != 0) begin n_bad++; $display("FAIL rand_data: %0d bad beats, want 0", data_errs()); end
      n_cmp++;
      if (RERR_REG !== 1'b0 || ar_unstable != 0) begin
         n_bad++; $display("FAIL rand_status: RERR=%b ar_unstable=%0d, want 0 0", RERR_REG, ar_unstable);
      end
      finish_xfer();
   endtask

   task automatic test_back_to_back();
      bit ok;
      for (int k = 0; k < 4; k++) begin
         p_arrdy = $urandom_range(40, 100); p_rvld = $urandom_range(40, 100); p_trdy = $urandom_range(40, 100);
         start_xfer(32'h8000 + $urandom_range(0, 4095), $urandom_range(1, 100));
         wait_done(5000, ok);
         n_cmp++;
         if (!ok) begin n_bad++; $display("FAIL b2b_done[%0d]: timed out, want RDONE 1", k); end
         n_cmp++;
         if (ar_errs() != 0 || ar_unstable != 0) begin
            n_bad++; $display("FAIL b2b_ar[%0d]: bad ARs=%0d unstable=%0d, want 0 0", k, ar_errs(), ar_unstable);
         end
         n_cmp++;
         if (data_errs() != 0) begin n_bad++; $display("FAIL b2b_data[%0d]: %0d bad beats, want 0", k, data_errs()); end
         finish_xfer();
      end
   endtask

   task automatic test_err_zero();
      bit ok;
      p_arrdy = 100; p_rvld = 100; p_trdy = 100;
      err_beat = 2;
      start_xfer(32'h2000, 10);
      wait_done(500, ok);
      n_cmp++;
      if (!ok || RERR_REG !== 1'b1) begin n_bad++; $display("FAIL err_sticky: done=%b RERR=%b, want 1 1", ok, RERR_REG); end
      n_cmp++;
      if (data_errs() != 0) begin n_bad++; $display("FAIL err_data: %0d bad beats, want 0", data_errs()); end
      finish_xfer();
      err_beat = -1;
      start_xfer(32'h2100, 0);
      wait_done(10, ok);
      n_cmp++;
      if (!ok || done_cyc - start_cyc > 3) begin
         n_bad++; $display("FAIL zero_len_done: done=%b after %0d cycles, want 1 within 3", ok, done_cyc - start_cyc);
      end
      n_cmp++;
      if (RERR_REG !== 1'b0 || obs_addr.size() != 0 || out_dat.size() != 0 || first_arv >= 0) begin
         n_bad++; $display("FAIL zero_len_status: RERR=%b ARs=%0d beats=%0d, want 0 0 0",
                           RERR_REG, obs_addr.size(), out_dat.size());
      end
      finish_xfer();
   endtask

   task automatic test_reset_mid();
      bit ok;
      int t = 0;
      start_xfer(32'h3000, 64);
      while (out_dat.size() < 20 && t < 500) begin @(negedge clk); t++; end
      rstn = 0; START_REG = 0;
      @(negedge clk);
      n_cmp++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.m_axi_arvalid !== 1'b0 || t >= 500) begin
         n_bad++; $display("FAIL reset_flush: tvalid=%b arvalid=%b waited=%0d, want 0 0 <500",
                           bus.m_axis_tvalid, bus.m_axi_arvalid, t);
      end
      @(negedge clk);
      rstn = 1;
      @(negedge clk);
      n_cmp++;
      if (RIDLE_REG !== 1'b1) begin n_bad++; $display("FAIL reset_mid_idle: got %b want 1", RIDLE_REG); end
      start_xfer(32'h5008, 40);
      wait_done(1000, ok);
      n_cmp++;
      if (!ok || ar_errs() != 0) begin n_bad++; $display("FAIL after_reset_ar: done=%b bad ARs=%0d, want 1 0", ok, ar_errs()); end
      n_cmp++;
      if (data_errs() != 0) begin n_bad++; $display("FAIL after_reset_data: %0d bad beats, want 0", data_errs()); end
      finish_xfer();
   endtask

   initial begin
      test_reset();
      test_single();
      test_split();
      test_backpressure();
      test_random();
      test_back_to_back();
      test_err_zero();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
